// File: rtl/lights_pkg.sv
// Shared constants and types for the lights datapath: channel slicing of the
// 24-bit {R,G,B} word and the fader's state encoding.
package lights_pkg;

    localparam int CHAN_W = 8;

    localparam int R_HI = 23;
    localparam int R_LO = 16;
    localparam int G_HI = 15;
    localparam int G_LO = 8;
    localparam int B_HI = 7;
    localparam int B_LO = 0;

    localparam logic [23:0] WHITE = 24'hFFFFFF;

    typedef enum logic {
        IDLE   = 1'b0,
        FADING = 1'b1
    } fade_state_t;

endpackage

// File: rtl/rgb_pwm_fader_pwm_channel.sv
// One colour channel: a displayed level that walks one LSB per step tick
// towards its target, plus the registered PWM comparator for that level.
module pwm_channel
    import lights_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              tick,
    input  logic [CHAN_W-1:0] target,
    input  logic [CHAN_W-1:0] cnt,
    output logic [CHAN_W-1:0] level,
    output logic              pwm,
    output logic              at_target
);

    localparam logic [CHAN_W-1:0] ONE = CHAN_W'(1);

    logic [CHAN_W-1:0] level_next;

    // Strict compares mean a step can never overshoot or wrap the level.
    always_comb begin
        level_next = level;
        if (tick && (level < target)) begin
            level_next = level + ONE;
        end else if (tick && (level > target)) begin
            level_next = level - ONE;
        end else begin
            level_next = level;
        end
    end

    // Level register and PWM drive; duty is level/256 against the shared count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
            pwm   <= 1'b0;
        end else begin
            level <= level_next;
            pwm   <= enable & (cnt < level);
        end
    end

    assign at_target = (level == target);

endmodule

// File: rtl/rgb_pwm_fader.sv
// Converts a requested {R,G,B} word into three PWM LED drives, fading each
// displayed level one LSB per STEP_DIV clocks towards the requested colour.
module rgb_pwm_fader
    import lights_pkg::*;
#(
    parameter int STEP_DIV = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [23:0] light,
    output logic        pwm_r,
    output logic        pwm_g,
    output logic        pwm_b,
    output logic [23:0] level,
    output logic        busy
);

    localparam logic [15:0] STEP_LAST = 16'(STEP_DIV - 1);

    logic [23:0]       target_q;
    logic [CHAN_W-1:0] cnt;
    logic [15:0]       presc;
    logic [15:0]       presc_next;
    fade_state_t       state;
    fade_state_t       state_next;
    logic              tick;
    logic [2:0]        at_tgt;
    logic              all_at;

    assign all_at = &at_tgt;

    // Target capture, free-running PWM count, prescaler and FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_q <= 24'h000000;
            cnt      <= '0;
            presc    <= 16'd0;
            state    <= IDLE;
        end else begin
            target_q <= light;
            cnt      <= cnt + CHAN_W'(1);
            presc    <= presc_next;
            state    <= state_next;
        end
    end

    // Next state and step tick; with enable low everything holds where it is.
    always_comb begin
        state_next = state;
        presc_next = presc;
        tick       = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !all_at) begin
                    state_next = FADING;
                    presc_next = 16'd0;
                end else begin
                    state_next = IDLE;
                end
            end
            FADING: begin
                if (enable) begin
                    if (presc == STEP_LAST) begin
                        tick       = 1'b1;
                        presc_next = 16'd0;
                    end else begin
                        presc_next = presc + 16'd1;
                    end
                    state_next = all_at ? IDLE : FADING;
                end else begin
                    state_next = FADING;
                end
            end
            default: begin
                state_next = IDLE;
                presc_next = 16'd0;
            end
        endcase
    end

    pwm_channel u_red (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .tick      (tick),
        .target    (target_q[R_HI:R_LO]),
        .cnt       (cnt),
        .level     (level[R_HI:R_LO]),
        .pwm       (pwm_r),
        .at_target (at_tgt[2])
    );

    pwm_channel u_green (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .tick      (tick),
        .target    (target_q[G_HI:G_LO]),
        .cnt       (cnt),
        .level     (level[G_HI:G_LO]),
        .pwm       (pwm_g),
        .at_target (at_tgt[1])
    );

    pwm_channel u_blue (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .tick      (tick),
        .target    (target_q[B_HI:B_LO]),
        .cnt       (cnt),
        .level     (level[B_HI:B_LO]),
        .pwm       (pwm_b),
        .at_target (at_tgt[0])
    );

    assign busy = (state == FADING);

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Directed self-checking bench for rgb_pwm_fader with a 4-cycle fade step.
module tb_rgb_pwm_fader;
    import lights_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [23:0] light;
    logic        pwm_r;
    logic        pwm_g;
    logic        pwm_b;
    logic [23:0] level;
    logic        busy;

    int tests  = 0;
    int failed = 0;

    rgb_pwm_fader #(.STEP_DIV(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .light  (light),
        .pwm_r  (pwm_r),
        .pwm_g  (pwm_g),
        .pwm_b  (pwm_b),
        .level  (level),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int hi_r;
        int hi_g;
        int hi_b;
        int guard;
        int prev;
        int cur;
        int maxr;
        int bad;
        int moves;

        // Reset hold with arbitrary input
        rst    = 1'b1;
        enable = 1'b1;
        light  = 24'($urandom);
        steps(3);
        chk("reset_pwm",   {29'd0, pwm_r, pwm_g, pwm_b}, 32'd0);
        chk("reset_level", {8'd0, level}, 32'd0);
        chk("reset_busy",  {31'd0, busy}, 32'd0);

        // Fade red 00 -> FF, STEP_DIV = 4
        rst   = 1'b0;
        light = 24'hFF0000;
        step();
        chk("busy_e1", {31'd0, busy}, 32'd0);
        step();
        chk("busy_e2", {31'd0, busy}, 32'd1);
        chk("level_e2", {8'd0, level}, 32'd0);
        steps(3);
        chk("r_before_first_step", {24'd0, level[23:16]}, 32'd0);
        step();
        chk("r_first_step", {8'd0, level}, 32'h010000);
        steps(1016);
        chk("r_full", {8'd0, level}, 32'hFF0000);
        chk("busy_at_full", {31'd0, busy}, 32'd1);
        step();
        chk("busy_drop", {31'd0, busy}, 32'd0);

        // Duty over a 256-cycle window at FF / 00
        hi_r = 0; hi_g = 0; hi_b = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            hi_r += int'(pwm_r);
            hi_g += int'(pwm_g);
            hi_b += int'(pwm_b);
        end
        chk("duty_ff", 32'(hi_r), 32'd255);
        chk("duty_00_g", 32'(hi_g), 32'd0);
        chk("duty_00_b", 32'(hi_b), 32'd0);

        // Steady level 40 on red
        light = 24'h400000;
        guard = 0;
        while ((busy !== 1'b0 || level !== 24'h400000) && guard < 3000) begin
            step();
            guard++;
        end
        chk("settle_40", {8'd0, level}, 32'h400000);
        hi_r = 0; hi_g = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            hi_r += int'(pwm_r);
            hi_g += int'(pwm_g);
        end
        chk("duty_40", 32'(hi_r), 32'd64);
        chk("duty_40_g", 32'(hi_g), 32'd0);

        // Asynchronous reset mid-cycle clears before the next edge
        #3;
        rst = 1'b1;
        #1;
        chk("async_level", {8'd0, level}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_pwm", {29'd0, pwm_r, pwm_g, pwm_b}, 32'd0);
        step();
        rst   = 1'b0;
        light = 24'hFF0000;

        // Mid-fade reversal at red level 10
        guard = 0;
        while (level[23:16] !== 8'h10 && guard < 2000) begin
            step();
            guard++;
        end
        chk("reach_10", {8'd0, level}, 32'h100000);
        light = 24'h050000;
        prev  = 16;
        maxr  = 16;
        bad   = 0;
        guard = 0;
        while (busy === 1'b1 && guard < 2000) begin
            step();
            guard++;
            cur = int'(level[23:16]);
            if (cur > prev + 1 || cur < prev - 1) bad++;
            if (cur > maxr) maxr = cur;
            prev = cur;
        end
        chk("rev_no_jump", 32'(bad), 32'd0);
        chk("rev_no_overshoot", 32'(maxr), 32'h10);
        chk("rev_final", {8'd0, level}, 32'h050000);

        // Disable during a fade at red level 20
        light = 24'hFF0000;
        guard = 0;
        while (level[23:16] !== 8'h20 && guard < 2000) begin
            step();
            guard++;
        end
        chk("reach_20", {8'd0, level}, 32'h200000);
        steps(2);
        enable = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if ({pwm_r, pwm_g, pwm_b} !== 3'b000 || level !== 24'h200000) bad++;
        end
        chk("disable_hold", 32'(bad), 32'd0);
        chk("disable_busy", {31'd0, busy}, 32'd1);
        enable = 1'b1;
        step();
        chk("resume_wait", {8'd0, level}, 32'h200000);
        step();
        chk("resume_step", {8'd0, level}, 32'h210000);

        // White then switch to pure green
        light = WHITE;
        guard = 0;
        while ((busy !== 1'b0 || level !== 24'hFFFFFF) && guard < 3000) begin
            step();
            guard++;
        end
        chk("white_settle", {8'd0, level}, 32'hFFFFFF);
        light = 24'h00FF00;
        prev  = 255;
        bad   = 0;
        moves = 0;
        guard = 0;
        while (!(busy === 1'b0 && level === 24'h00FF00) && guard < 3000) begin
            step();
            guard++;
            cur = int'(level[23:16]);
            if (level[23:16] !== level[7:0] || level[15:8] !== 8'hFF) bad++;
            if (cur == prev - 1) moves++;
            else if (cur != prev) bad++;
            prev = cur;
        end
        chk("rgb_switch_lockstep", 32'(bad), 32'd0);
        chk("rgb_switch_moves", 32'(moves), 32'd255);
        chk("rgb_switch_final", {8'd0, level}, 32'h00FF00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_fader.md
Name: rgb_pwm_fader

Overview:
- Downstream consumer of the lights selector's 24-bit RGB word (light[23:0]; R=[23:16], G=[15:8], B=[7:0]).
- Converts the word into three 8-bit PWM LED drive signals.
- Ramps each channel's displayed level one LSB per step towards the requested colour, so colour and white/RGB switches fade rather than jump.
- Sits between the lights selector and the board LED pins.

Parameters:
- STEP_DIV, 256: clock cycles per fade step. Legal range 1..65535. The prescaler is 16 bits.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- enable  input  1  1 = fade and drive; 0 = freeze levels and force PWM outputs low
- light  input  24  requested colour, {R,G,B}, 8 bits each
- pwm_r  output  1  red drive
- pwm_g  output  1  green drive
- pwm_b  output  1  blue drive
- level  output  24  currently displayed {R,G,B} levels
- busy  output  1  high while any channel level differs from its target

Behaviour:
- One clock (clk). Reset rst is asynchronous and active-high.
- Reset values:
  - target_q, level, PWM counter, prescaler: all 0.
  - pwm_r/g/b: 0. busy: 0. FSM: IDLE.
- Target capture: target_q <= light every cycle, regardless of enable. This gives 1 cycle of input latency.
- PWM counter:
  - 8-bit, free-running, increments every cycle, wraps 255->0.
  - Runs even when enable=0.
- PWM outputs (registered):
  - pwm_x <= enable & (cnt < level_x).
  - level 0 -> constantly low. level 255 -> high 255 of every 256 cycles.
  - Duty = level/256.
- FSM states: IDLE, FADING.
  - IDLE -> FADING when enable=1 and level != target_q. The prescaler clears to 0 on this transition.
  - FADING:
    - If enable=1, the prescaler increments.
    - When prescaler == STEP_DIV-1, a step tick fires and the prescaler returns to 0.
  - On a tick, each channel independently moves:
    - up by 1 if level_x < target_x;
    - down by 1 if level_x > target_x;
    - not at all if equal.
  - Levels never overshoot and never wrap; 8-bit saturation is implicit.
  - FADING -> IDLE on the cycle after level == target_q. The prescaler holds its value in IDLE.
- Step timing:
  - The first step occurs STEP_DIV cycles after entering FADING.
  - A full 0->255 fade takes 255*STEP_DIV cycles.
  - With STEP_DIV=1, a level moves every cycle.
- busy = (state == FADING). Registered; no combinational path from light.
- Target change mid-fade:
  - The new target applies immediately.
  - Each channel continues from its current level towards the new target.
  - No prescaler restart and no jump.
- Target equal to current level mid-fade: that channel stops. Other channels continue.
- enable=0:
  - Prescaler, levels and FSM state hold.
  - pwm_* are forced 0 from the next edge.
  - target_q still tracks light.
  - On re-enable, fading resumes from the held prescaler value.
- Reset mid-fade: everything returns to reset values asynchronously. The fade restarts from level 0 after rst falls.
- level output is the registered internal level (no extra delay).

Decomposition:
- Shared package lights_pkg:
  - CHAN_W = 8.
  - Channel slice constants R_HI/R_LO, G_HI/G_LO, B_HI/B_LO.
  - WHITE = 24'hFFFFFF.
  - FSM state encoding fade_state_t {IDLE, FADING}.
- Sub-module pwm_channel, instantiated three times:
  - Inputs: clk, rst, enable, step tick, target[7:0], shared PWM count.
  - Outputs: level[7:0], pwm, at_target.
- The top level owns the prescaler, PWM counter, FSM and the busy/at_target reduction.

Test Plan:
- Reset hold (rst=1 with random light) -> pwm_*=0, level=0, busy=0. Async check: assert rst mid-cycle and outputs clear before the next edge.
- STEP_DIV=4, enable=1, light=24'hFF0000 after reset -> busy rises 2 cycles later. level[23:16] reaches 1 at 4 cycles after FADING entry, then FF after 1020 cycles. G/B stay 0. busy falls 1 cycle after R==FF.
- Steady level 8'h40 on R -> over any 256-cycle window pwm_r is high exactly 64 cycles. Level 00 gives 0 high cycles; FF gives 255.
- Mid-fade reversal: fading R 00->FF, at level 8'h10 change light to 24'h050000 -> R decrements 10->05 with no jump, then busy drops.
- enable=0 during a fade at level 8'h20 for 100 cycles -> level holds 20, pwm_* all 0. On re-enable, the next step arrives after the remaining prescaler count.
- White/RGB switch: light 24'hFFFFFF to 24'h00FF00 with levels settled -> R and B ramp down and G holds FF. Each tick moves R and B together by exactly 1.
